// File: rtl/alarm_clock_ctrl.sv
// ----------------------------------------------------------------------------
// alarm_clock_ctrl
//
// User-interface sequencer for the alarm_clock timekeeping core. Turns three
// debounced button pulses into time/alarm edit sessions, issues the core's
// single-cycle load/stop strobes, and owns the ring / dismiss / snooze policy.
// A private copy of the user alarm is kept because the core's alarm registers
// cannot be read back.
//
// Ports
//   clk, reset                 10 Hz system clock, async active-high reset
//   btn_mode/btn_next/btn_inc  one-cycle debounced button pulses
//   alarm                      match indication from the core
//   sec/min/hour               current time from the core
//   sec_in/min_in/hour_in      shadow / edit value (also used for display)
//   LD_time/LD_alarm           one-cycle load strobes towards the core
//   stop_alarm                 one-cycle stop strobe towards the core
//   mode                       0 run, 1 edit time, 2 edit alarm, 3 ringing
//   field                      edit field: 0 hour, 1 min, 2 sec
//   armed                      user alarm enabled
//   buzzer                     ring indicator
// ----------------------------------------------------------------------------
module alarm_clock_ctrl #(
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       alarm,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    output logic [5:0] sec_in,
    output logic [5:0] min_in,
    output logic [5:0] hour_in,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       stop_alarm,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic       armed,
    output logic       buzzer
);

    typedef struct packed {
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } hms_t;

    // CLEAR is split in two so the dismiss/snooze decision needs no extra flag.
    typedef enum logic [3:0] {
        S_INIT, S_RUN, S_EDIT_T, S_LOAD_T, S_EDIT_A, S_LOAD_A, S_ARM,
        S_DISARM, S_RING, S_CLEAR_D, S_CLEAR_S, S_SNZ, S_REARM_WAIT, S_REARM
    } state_t;

    // Hour 63 never matches a real time, so loading it disarms the core.
    localparam hms_t SENTINEL = '{h: 6'd63, m: 6'd0, s: 6'd0};

    state_t     state_q, state_d;
    hms_t       shadow_q, shadow_d;
    hms_t       ualarm_q, ualarm_d;
    logic [1:0] field_q, field_d;
    logic [1:0] mode_q;
    logic       armed_q, armed_d;
    logic       buzzer_q, buzzer_d;
    logic       ld_time_q, ld_time_d;
    logic       ld_alarm_q, ld_alarm_d;
    logic       stop_q, stop_d;

    hms_t       cur_time;
    hms_t       snz_time;
    logic [6:0] snz_min_sum;
    logic [6:0] snz_hour_sum;
    logic       snz_carry;

    assign cur_time = '{h: hour, m: min, s: sec};

    // Snooze target: now + SNOOZE_MIN minutes, carried into the hour.
    assign snz_min_sum  = {1'b0, min} + 7'(SNOOZE_MIN);
    assign snz_carry    = (snz_min_sum >= 7'd60);
    assign snz_hour_sum = {1'b0, hour} + {6'd0, snz_carry};
    assign snz_time.s   = sec;
    assign snz_time.m   = snz_carry ? 6'(snz_min_sum - 7'd60) : snz_min_sum[5:0];
    assign snz_time.h   = (snz_hour_sum >= 7'd24) ? 6'(snz_hour_sum - 7'd24)
                                                  : snz_hour_sum[5:0];

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [6:0] modulus);
        logic [6:0] t;
        t = {1'b0, v} + 7'd1;
        return (t >= modulus) ? 6'd0 : t[5:0];
    endfunction

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            S_EDIT_T, S_LOAD_T:                     return 2'd1;
            S_EDIT_A, S_LOAD_A:                     return 2'd2;
            S_DISARM, S_RING, S_CLEAR_D, S_CLEAR_S: return 2'd3;
            default:                                return 2'd0;
        endcase
    endfunction

    // Outputs are registered: each transition computes the values that the
    // destination state presents, so a strobe is high while its state is.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        shadow_d   = shadow_q;
        ualarm_d   = ualarm_q;
        field_d    = field_q;
        armed_d    = armed_q;
        buzzer_d   = buzzer_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        stop_d     = 1'b0;

        case (state_q)
            S_INIT: begin
                // Core alarm registers are unreset; park them on the sentinel.
                state_d    = S_RUN;
                ld_alarm_d = 1'b1;
                shadow_d   = SENTINEL;
            end
            S_RUN: begin
                if (alarm) begin
                    state_d    = S_DISARM;
                    ld_alarm_d = 1'b1;
                    shadow_d   = SENTINEL;
                    buzzer_d   = 1'b1;
                end else if (btn_mode) begin
                    state_d  = S_EDIT_T;
                    shadow_d = cur_time;
                    field_d  = 2'd0;
                end else if (btn_next) begin
                    state_d    = S_ARM;
                    armed_d    = !armed_q;
                    ld_alarm_d = 1'b1;
                    shadow_d   = armed_q ? SENTINEL : ualarm_q;
                end
            end
            S_EDIT_T, S_EDIT_A: begin
                if (btn_mode) begin
                    if (state_q == S_EDIT_T) begin
                        state_d   = S_LOAD_T;
                        ld_time_d = 1'b1;
                    end else begin
                        state_d    = S_LOAD_A;
                        ualarm_d   = shadow_q;
                        ld_alarm_d = 1'b1;
                        if (!armed_q) shadow_d = SENTINEL;
                    end
                end else if (btn_next) begin
                    field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
                end else if (btn_inc) begin
                    case (field_q)
                        2'd0:    shadow_d.h = wrap_inc(shadow_q.h, 7'd24);
                        2'd1:    shadow_d.m = wrap_inc(shadow_q.m, 7'd60);
                        default: shadow_d.s = wrap_inc(shadow_q.s, 7'd60);
                    endcase
                end
            end
            S_LOAD_T: begin
                state_d  = S_EDIT_A;
                shadow_d = ualarm_q;
                field_d  = 2'd0;
            end
            S_LOAD_A, S_ARM, S_SNZ, S_REARM: state_d = S_RUN;
            S_DISARM: state_d = S_RING;
            S_RING: begin
                // btn_next outranks btn_inc but has no effect while ringing.
                if (btn_mode) begin
                    state_d = S_CLEAR_D;
                    stop_d  = 1'b1;
                end else if (!btn_next && btn_inc) begin
                    state_d = S_CLEAR_S;
                    stop_d  = 1'b1;
                end
            end
            S_CLEAR_D: begin
                state_d  = S_REARM_WAIT;
                buzzer_d = 1'b0;
            end
            S_CLEAR_S: begin
                state_d    = S_SNZ;
                buzzer_d   = 1'b0;
                ld_alarm_d = 1'b1;
                shadow_d   = snz_time;
            end
            S_REARM_WAIT: begin
                // Re-arming inside the matching second would ring again at once.
                if (cur_time != ualarm_q) begin
                    state_d    = S_REARM;
                    ld_alarm_d = 1'b1;
                    shadow_d   = ualarm_q;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            shadow_q   <= '0;
            ualarm_q   <= '0;
            field_q    <= 2'd0;
            mode_q     <= 2'd0;
            armed_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            ualarm_q   <= ualarm_d;
            field_q    <= field_d;
            mode_q     <= mode_of(state_d);
            armed_q    <= armed_d;
            buzzer_q   <= buzzer_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            stop_q     <= stop_d;
        end
    end

    assign hour_in    = shadow_q.h;
    assign min_in     = shadow_q.m;
    assign sec_in     = shadow_q.s;
    assign field      = field_q;
    assign mode       = mode_q;
    assign armed      = armed_q;
    assign buzzer     = buzzer_q;
    assign LD_time    = ld_time_q;
    assign LD_alarm   = ld_alarm_q;
    assign stop_alarm = stop_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alarm_clock_ctrl
//
// Self-checking bench for alarm_clock_ctrl. The core is replaced by directly
// driven time/alarm inputs. Expected values come from a session-level model:
// the user alarm and armed flag as plain integers, field arithmetic done with
// '%', and the snooze target computed in seconds-of-day.
// ----------------------------------------------------------------------------
module tb_alarm_clock_ctrl;

    localparam int SNZ = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, alarm = 1'b0;
    logic [5:0] sec = '0, min = '0, hour = '0;
    logic [5:0] sec_in, min_in, hour_in;
    logic       LD_time, LD_alarm, stop_alarm, armed, buzzer;
    logic [1:0] mode, field;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int  ua_h = 0, ua_m = 0, ua_s = 0;
    bit  m_armed = 1'b0;

    alarm_clock_ctrl #(.SNOOZE_MIN(SNZ)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .alarm(alarm), .sec(sec), .min(min), .hour(hour),
        .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .stop_alarm(stop_alarm),
        .mode(mode), .field(field), .armed(armed), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit pm, input bit pn, input bit pi);
        btn_mode = pm; btn_next = pn; btn_inc = pi;
        tick();
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour = 6'(h); min = 6'(m); sec = 6'(s);
    endtask

    task automatic chk_shadow(input string tag, input int h, input int m, input int s);
        check({tag, "_hour_in"}, 32'(hour_in), 32'(h));
        check({tag, "_min_in"},  32'(min_in),  32'(m));
        check({tag, "_sec_in"},  32'(sec_in),  32'(s));
    endtask

    task automatic chk_strobes(input string tag, input bit lt, input bit la, input bit sa);
        check({tag, "_LD_time"},    32'(LD_time),    32'(lt));
        check({tag, "_LD_alarm"},   32'(LD_alarm),   32'(la));
        check({tag, "_stop_alarm"}, 32'(stop_alarm), 32'(sa));
    endtask

    // Apply nh/nm/ns increments to hour/min/sec, walking field 0->1->2->0.
    task automatic edit_fields(input string tag, input int nh, input int nm, input int ns);
        repeat (nh) press(0, 0, 1);
        press(0, 1, 0);
        check({tag, "_field1"}, 32'(field), 1);
        repeat (nm) press(0, 0, 1);
        press(0, 1, 0);
        check({tag, "_field2"}, 32'(field), 2);
        repeat (ns) press(0, 0, 1);
        press(0, 1, 0);
        check({tag, "_field0"}, 32'(field), 0);
    endtask

    // RUN -> EDIT_T -> LOAD_T -> EDIT_A. inc_on_exit presses btn_inc together
    // with btn_mode, which must be dropped.
    task automatic edit_time(input int h, input int m, input int s,
                             input int nh, input int nm, input int ns, input bit inc_on_exit);
        set_time(h, m, s);
        press(1, 0, 0);
        check("et_mode", 32'(mode), 1);
        check("et_field", 32'(field), 0);
        chk_shadow("et_copy", h, m, s);
        // The core keeps running; the shadow must not follow it.
        set_time($urandom_range(23), $urandom_range(59), $urandom_range(59));
        edit_fields("et", nh, nm, ns);
        press(1, 0, inc_on_exit);
        chk_strobes("et_load", 1, 0, 0);
        chk_shadow("et_load", (h + nh) % 24, (m + nm) % 60, (s + ns) % 60);
        // btn_inc during LOAD_T is dropped; shadow becomes the user alarm.
        press(0, 0, 1);
        chk_strobes("et_post", 0, 0, 0);
        check("et_post_mode", 32'(mode), 2);
        check("et_post_field", 32'(field), 0);
        chk_shadow("et_post", ua_h, ua_m, ua_s);
    endtask

    // EDIT_A -> LOAD_A -> RUN, targeting the given alarm value.
    task automatic edit_alarm(input int th, input int tm, input int ts);
        edit_fields("ea", (th - ua_h + 24) % 24, (tm - ua_m + 60) % 60, (ts - ua_s + 60) % 60);
        ua_h = th; ua_m = tm; ua_s = ts;
        press(1, 0, 0);
        chk_strobes("ea_load", 0, 1, 0);
        if (m_armed) chk_shadow("ea_load", ua_h, ua_m, ua_s);
        else         chk_shadow("ea_load_sent", 63, 0, 0);
        tick();
        chk_strobes("ea_post", 0, 0, 0);
        check("ea_post_mode", 32'(mode), 0);
    endtask

    task automatic arm_toggle();
        press(0, 1, 0);
        m_armed = !m_armed;
        check("arm_armed", 32'(armed), 32'(m_armed));
        chk_strobes("arm", 0, 1, 0);
        if (m_armed) chk_shadow("arm", ua_h, ua_m, ua_s);
        else         chk_shadow("arm_sent", 63, 0, 0);
        tick();
        chk_strobes("arm_post", 0, 0, 0);
        check("arm_post_mode", 32'(mode), 0);
    endtask

    // Core matches the user alarm; then snooze (at time th:tm:ts) or dismiss.
    task automatic ring(input bit snooze, input int th, input int tm, input int ts);
        int t, eh, em, es;
        set_time(ua_h, ua_m, ua_s);
        alarm = 1'b1;
        btn_mode = 1'($urandom_range(1));   // alarm outranks buttons
        tick();
        alarm = 1'b0; btn_mode = 1'b0;
        chk_strobes("rg_disarm", 0, 1, 0);
        chk_shadow("rg_disarm", 63, 0, 0);
        check("rg_disarm_buzzer", 32'(buzzer), 1);
        tick();
        check("rg_mode", 32'(mode), 3);
        check("rg_buzzer", 32'(buzzer), 1);
        chk_strobes("rg_idle", 0, 0, 0);
        repeat ($urandom_range(2)) begin
            press(0, 1, 0);
            check("rg_next_mode", 32'(mode), 3);
            check("rg_next_armed", 32'(armed), 32'(m_armed));
        end
        if (snooze) begin
            set_time(th, tm, ts);
            press(0, 0, 1);
            chk_strobes("sz_clear", 0, 0, 1);
            check("sz_clear_buzzer", 32'(buzzer), 1);
            tick();
            t  = (th * 3600 + tm * 60 + ts + SNZ * 60) % 86400;
            eh = t / 3600; em = (t / 60) % 60; es = t % 60;
            chk_strobes("sz_load", 0, 1, 0);
            chk_shadow("sz_load", eh, em, es);
            check("sz_buzzer", 32'(buzzer), 0);
            check("sz_mode", 32'(mode), 0);
            tick();
            chk_strobes("sz_post", 0, 0, 0);
        end else begin
            press(1, 0, 0);
            chk_strobes("dm_clear", 0, 0, 1);
            tick();
            check("dm_buzzer", 32'(buzzer), 0);
            check("dm_mode", 32'(mode), 0);
            chk_strobes("dm_wait0", 0, 0, 0);
            repeat ($urandom_range(1, 4)) begin
                press(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
                chk_strobes("dm_wait", 0, 0, 0);
                check("dm_wait_mode", 32'(mode), 0);
            end
            sec = 6'((ua_s + 1) % 60);
            tick();
            chk_strobes("dm_rearm", 0, 1, 0);
            chk_shadow("dm_rearm", ua_h, ua_m, ua_s);
            tick();
            chk_strobes("dm_post", 0, 0, 0);
            check("dm_post_mode", 32'(mode), 0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk_strobes(tag, 0, 0, 0);
        chk_shadow(tag, 0, 0, 0);
        check({tag, "_mode"},   32'(mode),   0);
        check({tag, "_field"},  32'(field),  0);
        check({tag, "_armed"},  32'(armed),  0);
        check({tag, "_buzzer"}, 32'(buzzer), 0);
    endtask

    task automatic release_and_init(input string tag);
        reset = 1'b0;
        tick();
        chk_strobes({tag, "_init"}, 0, 1, 0);
        chk_shadow({tag, "_init"}, 63, 0, 0);
        tick();
        chk_strobes({tag, "_idle"}, 0, 0, 0);
        check({tag, "_idle_mode"}, 32'(mode), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk_reset_state("rst");
        release_and_init("rst");

        // Directed scenarios
        arm_toggle();
        edit_time(12, 59, 30, 3, 1, 0, 1'b1);
        edit_alarm(15, 0, 5);
        ring(1'b1, 23, 58, 10);
        ring(1'b0, 0, 0, 0);

        // Randomized sessions
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(2) == 0) arm_toggle();
            edit_time($urandom_range(23), $urandom_range(59), $urandom_range(59),
                      $urandom_range(30), $urandom_range(65), $urandom_range(65),
                      1'($urandom_range(1)));
            edit_alarm($urandom_range(23), $urandom_range(59), $urandom_range(59));
            if (m_armed)
                ring(1'($urandom_range(1)), $urandom_range(23), $urandom_range(59),
                     $urandom_range(59));
        end

        // Reset mid-edit: shadow discarded, no strobe, INIT repeats.
        set_time(7, 8, 9);
        press(1, 0, 0);
        press(0, 0, 1);
        reset = 1'b1;
        #2;
        chk_reset_state("rst_mid");
        tick();
        chk_reset_state("rst_mid_hold");
        m_armed = 1'b0; ua_h = 0; ua_m = 0; ua_s = 0;
        release_and_init("rst_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

User-interface sequencer for the `alarm_clock` timekeeping core. It turns three debounced push-button pulses into edit sessions for the time and alarm values, and issues the core's single-cycle `LD_time` / `LD_alarm` / `stop_alarm` strobes. It also owns the ring / dismiss / snooze policy. It sits between the button conditioning logic and `alarm_clock`, and keeps its own copy of the user alarm because the core's alarm registers are not readable.

## Interface
- `SNOOZE_MIN`, default 5: snooze length in minutes; legal range 1..59.
- `clk` in 1: system clock, the same 10 Hz clock as `alarm_clock`.
- `reset` in 1: asynchronous, active-high; all registers clear immediately.
- `btn_mode`, `btn_next`, `btn_inc` in 1 each: one-cycle, synchronous, debounced pulses.
- `alarm` in 1: `alarm` output of the core.
- `sec`, `min`, `hour` in 6 each: current time from the core.
- `sec_in`, `min_in`, `hour_in` out 6 each: shadow/edit value. Continuously driven (also used for display); sampled by the core only under a strobe.
- `LD_time`, `LD_alarm`, `stop_alarm` out 1 each: one-cycle registered strobes. At most one is high in any cycle.
- `mode` out 2: 0 = run, 1 = edit time, 2 = edit alarm, 3 = ringing.
- `field` out 2: edit field select; 0 = hour, 1 = min, 2 = sec.
- `armed` out 1: user alarm enabled.
- `buzzer` out 1: ring indicator.

## Operation
- Sentinel value: hour 63, min 0, sec 0. It never matches a real time, so loading it disarms the core comparator.
- INIT: first state after reset.
  - Drive the sentinel with `LD_alarm` = 1 for one cycle, because core alarm registers are unreset.
  - Then go to RUN.
- RUN:
  - `btn_mode`: copy `hour`/`min`/`sec` into the shadow, set `field` = 0, go to EDIT_T.
  - `btn_next`: toggle `armed`, go to ARM.
  - `alarm` = 1: go to DISARM. This has priority over buttons in the same cycle.
- EDIT_T and EDIT_A:
  - `btn_next` cycles `field` 0→1→2→0.
  - `btn_inc` adds 1 to the selected shadow field. Hour wraps 23→0; min and sec wrap 59→0. There is no carry between fields.
- Leaving EDIT_T:
  - `btn_mode` goes to LOAD_T: `LD_time` for one cycle.
  - LOAD_T then loads the stored user alarm into the shadow, sets `field` = 0, and goes to EDIT_A.
- Leaving EDIT_A:
  - `btn_mode` goes to LOAD_A: the shadow is copied into the user-alarm register.
  - If `armed` = 1: `LD_alarm` with the shadow. If `armed` = 0: `LD_alarm` with the sentinel.
  - Then go to RUN.
- ARM: one cycle of `LD_alarm` with the user alarm if `armed` = 1, else with the sentinel; then RUN.
- DISARM:
  - One cycle of `LD_alarm` with the sentinel. This stops the core's repeated match, which otherwise freezes its time.
  - Set `buzzer` = 1, go to RING.
- RING (`mode` = 3):
  - `btn_mode` (dismiss): go to CLEAR, then REARM_WAIT.
  - `btn_inc` (snooze): go to CLEAR, then SNZ.
  - `btn_next` is ignored.
- CLEAR: `stop_alarm` for one cycle; `buzzer` drops at the end of this cycle.
- SNZ: one cycle of `LD_alarm` with `sec`, `min` + `SNOOZE_MIN` mod 60, and `hour` + carry mod 24. The user alarm register is not modified. Then RUN.
- REARM_WAIT:
  - Hold until the current `hour`/`min`/`sec` differs from the user alarm. This prevents an immediate re-match within the same second.
  - Then REARM: one cycle of `LD_alarm` with the user alarm, then RUN.
  - Both states report `mode` = 0.
- Buttons arriving in LOAD_*, ARM, DISARM, CLEAR, SNZ, REARM_WAIT or REARM are dropped.
- Width rule: all arithmetic uses 7-bit intermediates and is reduced mod 60 or mod 24 before reaching the 6-bit outputs.

## Timing
- Reset values:
  - All strobes 0; `buzzer` 0; `armed` 0; `mode` 0; `field` 0.
  - `sec_in`/`min_in`/`hour_in` 0; user alarm 00:00:00.
  - State is INIT on reset release.
- All outputs are registered.
- The shadow holds the loaded value in the same cycle as its strobe.
- Alarm reaction:
  - `alarm` is sampled high at edge N.
  - `LD_alarm` (sentinel) is high during cycle N+1.
  - The core therefore loses at most 2 ticks (0.2 s).
- Edit latency: `btn_inc` at edge N changes the shadow at N+1.
- Reset asserted mid-edit or mid-ring: the shadow is discarded and no strobe is emitted. After release, the INIT sentinel load is repeated.
- Simultaneous buttons: `btn_mode` > `btn_next` > `btn_inc`; the lower-priority pulses are dropped.

## Test plan
- Reset release: one `LD_alarm` with `hour_in` = 63 in the first cycle after INIT, then idle with `mode` = 0.
- Set time: `btn_mode`, `btn_inc` ×3 (hour 12→15), `btn_next`, `btn_inc` (min 59→0), `btn_mode` → one `LD_time` pulse with 15:00:ss, `mode` = 2.
- Set alarm to 15:00:05 with `armed` = 1 → `LD_alarm` carries 15:00:05. At match, sentinel `LD_alarm` follows exactly one cycle after `alarm` rises, and `buzzer` = 1.
- Snooze at 23:58:10 with `SNOOZE_MIN` = 5 → `stop_alarm` pulse, then `LD_alarm` with 00:03:10; the user alarm register is unchanged.
- Dismiss within the matching second → no `LD_alarm` until the time leaves 15:00:05, then one `LD_alarm` with 15:00:05.
- `btn_mode` and `btn_inc` in the same cycle during EDIT_T → only `LD_time` occurs, and the shadow is not incremented.
